// File: rtl/vec_inst_issue_if.sv
// rtl/vec_inst_issue_if.sv - scalar-core / vector-unit issue bus bundle
interface vec_inst_issue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            s_valid;
   logic [31:0]     s_inst;
   logic [XLEN-1:0] s_rs1_data;
   logic [XLEN-1:0] s_rs2_data;
   logic            s_ready;
   logic            s_illegal;
   logic            flush;
   logic            vec_ready;
   logic [31:0]     vec_inst;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] csr_out;
   logic            rd_wb_valid;
   logic [4:0]      rd_wb_addr;
   logic [XLEN-1:0] rd_wb_data;
   logic [CW-1:0]   fifo_count;

   modport slave (
      input  s_valid, s_inst, s_rs1_data, s_rs2_data, flush, vec_ready, csr_out,
      output s_ready, s_illegal, vec_inst, rs1_data, rs2_data,
             rd_wb_valid, rd_wb_addr, rd_wb_data, fifo_count
   );

   modport master (
      output s_valid, s_inst, s_rs1_data, s_rs2_data, flush, vec_ready, csr_out,
      input  s_ready, s_illegal, vec_inst, rs1_data, rs2_data,
             rd_wb_valid, rd_wb_addr, rd_wb_data, fifo_count
   );
endinterface

// File: rtl/vec_inst_issue.sv
// rtl/vec_inst_issue.sv - vector instruction issue FIFO with vset writeback sequencing
// Optional VEC_ISSUE_BYPASS_EN: empty idle unit loads accepted words straight to the outputs.
module vec_inst_issue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input logic             clk,
   input logic             n_rst,
   vec_inst_issue_if.slave bus
);
   localparam int            AW   = $clog2(DEPTH);
   localparam int            CW   = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, CFG_ISSUE, CFG_WAIT} state_t;

   state_t          r_state, w_next;
   logic [31:0]     r_mem_inst [DEPTH];
   logic [XLEN-1:0] r_mem_rs1  [DEPTH];
   logic [XLEN-1:0] r_mem_rs2  [DEPTH];
   logic [AW-1:0]   r_wptr, r_rptr;
   logic [CW-1:0]   r_count;
   logic [31:0]     r_vec_inst;
   logic [XLEN-1:0] r_rs1, r_rs2;
   logic            r_illegal;
   logic [4:0]      r_rd_addr;

   logic            w_full, w_empty, w_accept, w_is_vec;
   logic            w_push, w_pop, w_bypass, w_load, w_wb;
   logic [31:0]     w_load_inst;
   logic [XLEN-1:0] w_load_rs1, w_load_rs2;

   function automatic logic f_is_vec(input logic [31:0] inst);
      return (inst[6:0] == 7'h57) ||
             (((inst[6:0] == 7'h07) || (inst[6:0] == 7'h27)) &&
              ((inst[14:12] == 3'b000) || (inst[14:12] == 3'b101) ||
               (inst[14:12] == 3'b110) || (inst[14:12] == 3'b111)));
   endfunction

   function automatic logic f_is_vset(input logic [31:0] inst);
      return (inst[6:0] == 7'h57) && (inst[14:12] == 3'b111);
   endfunction

   assign w_full   = (r_count == FULL);
   assign w_empty  = (r_count == '0);
   assign w_accept = bus.s_valid && !w_full;
   assign w_is_vec = f_is_vec(bus.s_inst);

   always_comb begin
      w_next      = r_state;
      w_pop       = 1'b0;
      w_bypass    = 1'b0;
      w_load_inst = r_mem_inst[r_rptr];
      w_load_rs1  = r_mem_rs1[r_rptr];
      w_load_rs2  = r_mem_rs2[r_rptr];
      case (r_state)
         IDLE: begin
            if (!bus.flush && bus.vec_ready && !w_empty) begin
               w_pop = 1'b1;
            end
`ifdef VEC_ISSUE_BYPASS_EN
            else if (!bus.flush && bus.vec_ready && w_accept && w_is_vec) begin
               w_bypass    = 1'b1;
               w_load_inst = bus.s_inst;
               w_load_rs1  = bus.s_rs1_data;
               w_load_rs2  = bus.s_rs2_data;
            end
`endif
            if ((w_pop || w_bypass) && f_is_vset(w_load_inst)) begin
               w_next = CFG_ISSUE;
            end
         end
         CFG_ISSUE: w_next = CFG_WAIT;
         CFG_WAIT:  w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   assign w_load = w_pop || w_bypass;
   // A bypassed word never occupies a FIFO slot; flush drops any same-edge push.
   assign w_push = w_accept && w_is_vec && !bus.flush && !w_bypass;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_inst[r_wptr] <= bus.s_inst;
         r_mem_rs1[r_wptr]  <= bus.s_rs1_data;
         r_mem_rs2[r_wptr]  <= bus.s_rs2_data;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (bus.flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_vec_inst <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_illegal  <= 1'b0;
         r_rd_addr  <= '0;
      end else begin
         r_vec_inst <= w_load ? w_load_inst : '0;
         r_rs1      <= w_load ? w_load_rs1  : '0;
         r_rs2      <= w_load ? w_load_rs2  : '0;
         r_illegal  <= w_accept && !w_is_vec;
         if (w_load) r_rd_addr <= w_load_inst[11:7];
      end
   end

   assign w_wb = (r_state == CFG_WAIT);

   assign bus.s_ready     = !w_full;
   assign bus.s_illegal   = r_illegal;
   assign bus.vec_inst    = r_vec_inst;
   assign bus.rs1_data    = r_rs1;
   assign bus.rs2_data    = r_rs2;
   assign bus.rd_wb_valid = w_wb;
   assign bus.rd_wb_addr  = w_wb ? r_rd_addr : 5'd0;
   assign bus.rd_wb_data  = w_wb ? bus.csr_out : '0;
   assign bus.fifo_count  = r_count;
endmodule

// File: tb/tb_vec_inst_issue.sv
// tb/tb_vec_inst_issue.sv - directed table and sequence bench for vec_inst_issue
module tb_vec_inst_issue;
   localparam logic [31:0] CSR = 32'h0000_0010;
`ifdef VEC_ISSUE_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   vec_inst_issue_if #(.XLEN(32), .DEPTH(4)) bus ();
   vec_inst_issue #(.XLEN(32), .DEPTH(4)) dut (.clk(clk), .n_rst(n_rst), .bus(bus.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] inst;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        vr;
      logic [31:0] e_inst;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      logic        e_ill;
      logic [2:0]  e_cnt;
      logic        e_rdy;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] rs1,
                        input logic [31:0] rs2);
      bus.s_valid    = v;
      bus.s_inst     = inst;
      bus.s_rs1_data = rs1;
      bus.s_rs2_data = rs2;
   endtask

   task automatic chk_outs(input string tag, input logic [31:0] e_inst, input logic [31:0] e_rs1,
                           input logic [31:0] e_rs2, input logic e_wbv, input logic [4:0] e_wba);
      chk({tag, ".vec_inst"}, 64'(bus.vec_inst), 64'(e_inst));
      chk({tag, ".rs1_data"}, 64'(bus.rs1_data), 64'(e_rs1));
      chk({tag, ".rs2_data"}, 64'(bus.rs2_data), 64'(e_rs2));
      chk({tag, ".rd_wb_valid"}, 64'(bus.rd_wb_valid), 64'(e_wbv));
      chk({tag, ".rd_wb_addr"}, 64'(bus.rd_wb_addr), 64'(e_wba));
      chk({tag, ".rd_wb_data"}, 64'(bus.rd_wb_data), e_wbv ? 64'(CSR) : 64'd0);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 32'h00000013, 32'h0, 32'h0,  1'b0, 32'h0,        32'h0, 32'h0,  1'b1, 3'd0, 1'b1};
      tbl[1]  = '{1'b0, 32'h00000000, 32'h0, 32'h0,  1'b0, 32'h0,        32'h0, 32'h0,  1'b0, 3'd0, 1'b1};
      tbl[2]  = '{1'b1, 32'h02000057, 32'h1, 32'h10, 1'b0, 32'h0,        32'h0, 32'h0,  1'b0, 3'd1, 1'b1};
      tbl[3]  = '{1'b1, 32'h02100057, 32'h2, 32'h20, 1'b0, 32'h0,        32'h0, 32'h0,  1'b0, 3'd2, 1'b1};
      tbl[4]  = '{1'b1, 32'h02200057, 32'h3, 32'h30, 1'b0, 32'h0,        32'h0, 32'h0,  1'b0, 3'd3, 1'b1};
      tbl[5]  = '{1'b1, 32'h02300057, 32'h4, 32'h40, 1'b0, 32'h0,        32'h0, 32'h0,  1'b0, 3'd4, 1'b0};
      tbl[6]  = '{1'b1, 32'h02400057, 32'h5, 32'h50, 1'b0, 32'h0,        32'h0, 32'h0,  1'b0, 3'd4, 1'b0};
      tbl[7]  = '{1'b0, 32'h00000000, 32'h0, 32'h0,  1'b1, 32'h02000057, 32'h1, 32'h10, 1'b0, 3'd3, 1'b1};
      tbl[8]  = '{1'b0, 32'h00000000, 32'h0, 32'h0,  1'b1, 32'h02100057, 32'h2, 32'h20, 1'b0, 3'd2, 1'b1};
      tbl[9]  = '{1'b0, 32'h00000000, 32'h0, 32'h0,  1'b1, 32'h02200057, 32'h3, 32'h30, 1'b0, 3'd1, 1'b1};
      tbl[10] = '{1'b0, 32'h00000000, 32'h0, 32'h0,  1'b1, 32'h02300057, 32'h4, 32'h40, 1'b0, 3'd0, 1'b1};
      tbl[11] = '{1'b0, 32'h00000000, 32'h0, 32'h0,  1'b1, 32'h0,        32'h0, 32'h0,  1'b0, 3'd0, 1'b1};
      tbl[12] = '{1'b1, 32'h00002007, 32'h0, 32'h0,  1'b0, 32'h0,        32'h0, 32'h0,  1'b1, 3'd0, 1'b1};
      tbl[13] = '{1'b1, 32'h00005027, 32'h7, 32'h70, 1'b0, 32'h0,        32'h0, 32'h0,  1'b0, 3'd1, 1'b1};
      tbl[14] = '{1'b0, 32'h00000000, 32'h0, 32'h0,  1'b1, 32'h00005027, 32'h7, 32'h70, 1'b0, 3'd0, 1'b1};
      tbl[15] = '{1'b0, 32'h00000000, 32'h0, 32'h0,  1'b0, 32'h0,        32'h0, 32'h0,  1'b0, 3'd0, 1'b1};

      drive(1'b0, 32'h0, 32'h0, 32'h0);
      bus.flush     = 1'b0;
      bus.vec_ready = 1'b0;
      bus.csr_out   = CSR;

      // Reset state, sampled while reset is held.
      repeat (2) @(negedge clk);
      chk_outs("reset", 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
      chk("reset.fifo_count", 64'(bus.fifo_count), 64'd0);
      chk("reset.s_ready", 64'(bus.s_ready), 64'd1);
      chk("reset.s_illegal", 64'(bus.s_illegal), 64'd0);
      n_rst = 1'b1;

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].v, tbl[i].inst, tbl[i].rs1, tbl[i].rs2);
         bus.vec_ready = tbl[i].vr;
         step();
         chk_outs($sformatf("tbl%0d", i), tbl[i].e_inst, tbl[i].e_rs1, tbl[i].e_rs2, 1'b0, 5'd0);
         chk($sformatf("tbl%0d.s_illegal", i), 64'(bus.s_illegal), 64'(tbl[i].e_ill));
         chk($sformatf("tbl%0d.fifo_count", i), 64'(bus.fifo_count), 64'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d.s_ready", i), 64'(bus.s_ready), 64'(tbl[i].e_rdy));
      end

      // Single vsetvli: one-cycle issue then writeback to x0.
      bus.vec_ready = 1'b1;
      drive(1'b1, 32'h01007057, 32'h0000000F, 32'h00001200);
      for (int k = 1; k <= 5; k++) begin
         step();
         drive(1'b0, 32'h0, 32'h0, 32'h0);
         chk_outs($sformatf("vset_k%0d", k),
                  (k == LAT) ? 32'h01007057 : 32'h0,
                  (k == LAT) ? 32'h0000000F : 32'h0,
                  (k == LAT) ? 32'h00001200 : 32'h0,
                  k == LAT + 1, 5'd0);
      end

      // vset followed back-to-back by a vector load held off until CFG_WAIT ends.
      drive(1'b1, 32'hc1087157, 32'h00000005, 32'h0);
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 1) drive(1'b1, 32'h02016107, 32'hDEADBEAF, 32'h0);
         else        drive(1'b0, 32'h0, 32'h0, 32'h0);
         chk_outs($sformatf("b2b_k%0d", k),
                  (k == LAT) ? 32'hc1087157 : ((k == LAT + 3) ? 32'h02016107 : 32'h0),
                  (k == LAT) ? 32'h00000005 : ((k == LAT + 3) ? 32'hDEADBEAF : 32'h0),
                  32'h0, k == LAT + 1, (k == LAT + 1) ? 5'd2 : 5'd0);
      end
      chk("b2b.fifo_count", 64'(bus.fifo_count), 64'd0);

      // Asynchronous reset while in CFG_ISSUE with another word queued behind.
      drive(1'b1, 32'h01007057, 32'h1, 32'h2);
      for (int k = 1; k <= LAT; k++) begin
         step();
         if (k == 1) drive(1'b1, 32'h02000057, 32'h3, 32'h4);
         else        drive(1'b0, 32'h0, 32'h0, 32'h0);
      end
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      chk("rst_mid.pre_vec_inst", 64'(bus.vec_inst), 64'h01007057);
      #1 n_rst = 1'b0;
      #1;
      chk_outs("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
      chk("rst_mid.fifo_count", 64'(bus.fifo_count), 64'd0);
      chk("rst_mid.s_ready", 64'(bus.s_ready), 64'd1);
      #1 n_rst = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk_outs($sformatf("rst_after_k%0d", k), 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
         chk($sformatf("rst_after_k%0d.fifo_count", k), 64'(bus.fifo_count), 64'd0);
      end

      // Flush empties the queue and drops the same-edge push.
      bus.vec_ready = 1'b0;
      drive(1'b1, 32'h02000057, 32'h1, 32'h1);
      step();
      drive(1'b1, 32'h02100057, 32'h2, 32'h2);
      step();
      chk("flush.pre_count", 64'(bus.fifo_count), 64'd2);
      bus.flush = 1'b1;
      drive(1'b1, 32'h02200057, 32'h3, 32'h3);
      step();
      chk("flush.count", 64'(bus.fifo_count), 64'd0);
      bus.flush = 1'b0;
      bus.vec_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      step();
      chk("flush.post_vec_inst", 64'(bus.vec_inst), 64'd0);
      chk("flush.post_count", 64'(bus.fifo_count), 64'd0);

      // Flush during CFG_ISSUE still lets the writeback happen.
      drive(1'b1, 32'hc1087157, 32'h9, 32'h0);
      for (int k = 1; k <= LAT + 2; k++) begin
         step();
         drive(1'b0, 32'h0, 32'h0, 32'h0);
         bus.flush = (k == LAT);
         if (k == LAT + 1) begin
            chk("flush_cfg.rd_wb_valid", 64'(bus.rd_wb_valid), 64'd1);
            chk("flush_cfg.rd_wb_addr", 64'(bus.rd_wb_addr), 64'd2);
         end
      end
      chk("flush_cfg.end_wb_valid", 64'(bus.rd_wb_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end
endmodule

// File: doc/vec_inst_issue.md
VEC_INST_ISSUE -- requirements
Module: vec_inst_issue

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, scalar data width; DEPTH, default 4, issue FIFO entries (power of 2, at least 2).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 n_rst  in  1  reset, asynchronous and active-low.
REQ-004 s_valid  in  1  scalar core offers an instruction.
REQ-005 s_inst  in  32  offered instruction word.
REQ-006 s_rs1_data / s_rs2_data  in  XLEN  operand values read by the scalar core.
REQ-007 s_ready  out  1  issue unit can accept; s_ready = !full.
REQ-008 s_illegal  out  1  registered one-cycle pulse; the last accepted word was not a vector instruction.
REQ-009 flush  in  1  synchronous FIFO flush.
REQ-010 vec_ready  in  1  vector unit can take a new instruction.
REQ-011 vec_inst  out  32  registered instruction to vec_csr_dec; 0 means no instruction.
REQ-012 rs1_data / rs2_data  out  XLEN  registered operands matching vec_inst.
REQ-013 csr_out  in  XLEN  vl result returned by vec_csr_dec.
REQ-014 rd_wb_valid / rd_wb_addr[4:0] / rd_wb_data[XLEN-1:0]  out  scalar rd writeback of the vl result.
REQ-015 fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Vector classification SHALL be one of:
- opcode 7'h57 (OP-V);
- opcode 7'h07 or 7'h27 with width s_inst[14:12] in {000,101,110,111}.
REQ-017 Configuration instructions (vset*) SHALL be OP-V with funct3 3'b111.
REQ-018 Handshake SHALL be: a transfer occurs when s_valid && s_ready at the edge.
- Vector words are pushed as {inst, rs1, rs2}.
- Non-vector words are dropped and pulse s_illegal in the next cycle.
REQ-019 FSM states SHALL be IDLE, CFG_ISSUE and CFG_WAIT.
REQ-020 IDLE: with the FIFO non-empty and vec_ready=1, the head SHALL be popped into the output registers at the edge.
- Non-vset head: stay in IDLE.
- vset head: go to CFG_ISSUE.
REQ-021 When no pop occurs, vec_inst SHALL be 0 in the following cycle; each instruction is presented for exactly one cycle.
REQ-022 CFG_ISSUE SHALL hold the vset instruction on vec_inst for that one cycle, then go to CFG_WAIT with vec_inst=0; no pop occurs in either state.
REQ-023 CFG_WAIT SHALL assert rd_wb_valid=1, with:
- rd_wb_addr = vset inst[11:7];
- rd_wb_data = csr_out, combinationally.
On the next edge it returns to IDLE. rd_wb_valid SHALL be 0 in all other states.
REQ-024 Push and pop in the same edge SHALL leave the count unchanged. A push is accepted only if the FIFO was not full before the edge: no pass-through of a same-cycle pop.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH. Full means count==DEPTH; empty means count==0.
REQ-026 With FIFO empty and DEPTH-1 pops pending, latency SHALL be: word accepted at edge E appears on vec_inst after edge E+1 (2 cycles).
REQ-027 flush SHALL empty the FIFO and block pushes and pops at that edge. An in-progress CFG_ISSUE/CFG_WAIT sequence still completes its writeback.
REQ-028 A vec_ready drop SHALL only block new pops; the already-issued output still clears after one cycle.

Reset
REQ-029 On n_rst=0, asynchronously:
- FIFO is emptied and fifo_count=0;
- state is IDLE;
- vec_inst, rs1_data and rs2_data are 0;
- s_illegal=0, rd_wb_valid=0, s_ready=1.
REQ-030 Reset mid-sequence SHALL discard any pending writeback and queued entries.

Configuration
REQ-031 Macro VEC_ISSUE_BYPASS_EN, when defined, adds a bypass. With FIFO empty, state IDLE and vec_ready=1, an accepted vector word loads the output registers directly at edge E, skipping the FIFO. Latency is then 1 cycle. vset words still enter CFG_ISSUE.
REQ-032 When VEC_ISSUE_BYPASS_EN is undefined, all words pass through the FIFO (REQ-026 latency).

Verification
REQ-033 Accept 32'h01007057 with rs1=32'hF, rs2=32'h1200.
- vec_inst=32'h01007057 for exactly one cycle.
- Next cycle: rd_wb_valid=1, rd_wb_addr=0, rd_wb_data=csr_out.
REQ-034 Back-to-back 32'hc1087157 then 32'h02016107.
- Second word is not issued until CFG_WAIT ends.
- rd_wb_addr=2.
- Load issued with rs1=32'hDEADBEAF.
REQ-035 Accept 32'h00000013 -> s_illegal=1 for one cycle, fifo_count stays 0, vec_inst stays 0.
REQ-036 vec_ready=0, push 4 words.
- fifo_count=4 and s_ready=0; a 5th offer is not accepted.
- Raise vec_ready: the 4 words issue in order, one per cycle.
REQ-037 Assert n_rst=0 during CFG_ISSUE -> all outputs 0 immediately, no rd_wb_valid afterwards, fifo_count=0.
REQ-038 With VEC_ISSUE_BYPASS_EN defined, accept an OP-V word into an empty idle unit -> vec_inst valid 1 cycle after acceptance.
